// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side and memory-side signals of the unified memory port arbiter
interface mem_port_arbiter_if #(
    parameter int BIT_NUMBER = 32
);
    logic                  if_req;
    logic [BIT_NUMBER-1:0] if_addr;
    logic                  if_abort;
    logic                  if_ready;
    logic [BIT_NUMBER-1:0] if_rdata;
    logic                  if_freeze;
    logic                  data_req;
    logic                  data_we;
    logic [BIT_NUMBER-1:0] data_addr;
    logic [BIT_NUMBER-1:0] data_wdata;
    logic                  data_ready;
    logic [BIT_NUMBER-1:0] data_rdata;
    logic                  port_en;
    logic                  port_we;
    logic [BIT_NUMBER-1:0] port_addr;
    logic [BIT_NUMBER-1:0] port_wdata;
    logic [BIT_NUMBER-1:0] port_rdata;
    modport master (
        output if_req, if_addr, if_abort, data_req, data_we, data_addr, data_wdata, port_rdata,
        input  if_ready, if_rdata, if_freeze, data_ready, data_rdata,
               port_en, port_we, port_addr, port_wdata
    );
    modport slave (
        input  if_req, if_addr, if_abort, data_req, data_we, data_addr, data_wdata, port_rdata,
        output if_ready, if_rdata, if_freeze, data_ready, data_rdata,
               port_en, port_we, port_addr, port_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between IF fetch and MEM data access; define ARB_RR_EN for round-robin contention
module mem_port_arbiter #(
    parameter int BIT_NUMBER = 32,
    parameter int LATENCY    = 2
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(LATENCY) + 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic                  abort_q, abort_d;
    logic [BIT_NUMBER-1:0] addr_q, addr_d;
    logic [BIT_NUMBER-1:0] wdata_q, wdata_d;
    logic [BIT_NUMBER-1:0] if_rdata_q, if_rdata_d;
    logic [BIT_NUMBER-1:0] data_rdata_q, data_rdata_d;
    logic                  grant_if;
`ifdef ARB_RR_EN
    logic                  prio_q, prio_d;
    assign grant_if = bus.if_req & (~bus.data_req | prio_q);
`else
    assign grant_if = bus.if_req & ~bus.data_req;
`endif
    assign bus.port_en    = state_q == ACCESS;
    assign bus.port_we    = bus.port_en & we_q;
    assign bus.port_addr  = addr_q;
    assign bus.port_wdata = wdata_q;
    assign bus.if_ready   = (state_q == RESPOND) & owner_q & ~abort_q;
    assign bus.data_ready = (state_q == RESPOND) & ~owner_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.if_freeze  = bus.if_req & ~bus.if_ready;
    // Next state: grant and latch in IDLE, count down the access, capture read data on its last cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        abort_d      = abort_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        data_rdata_d = data_rdata_q;
`ifdef ARB_RR_EN
        prio_d       = prio_q;
`endif
        case (state_q)
            IDLE: if (bus.if_req | bus.data_req) begin
                state_d = ACCESS;
                cnt_d   = CW'(LATENCY - 1);
                owner_d = grant_if;
                we_d    = ~grant_if & bus.data_we;
                addr_d  = grant_if ? bus.if_addr : bus.data_addr;
                wdata_d = grant_if ? wdata_q : bus.data_wdata;
`ifdef ARB_RR_EN
                if (bus.if_req & bus.data_req) prio_d = ~prio_q;
`endif
            end
            ACCESS: begin
                if (owner_q & bus.if_abort) abort_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESPOND;
                    if (owner_q & ~(abort_q | bus.if_abort)) if_rdata_d = bus.port_rdata;
                    if (~owner_q & ~we_q) data_rdata_d = bus.port_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
                abort_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and latched-request registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            abort_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            data_rdata_q <= '0;
`ifdef ARB_RR_EN
            prio_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            abort_q      <= abort_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            data_rdata_q <= data_rdata_d;
`ifdef ARB_RR_EN
            prio_q       <= prio_d;
`endif
        end
    end
endmodule
